// File: rtl/wb_seq_pkg.sv
// Shared types and default widths for the Wishbone command sequencer.
package wb_seq_pkg;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_DEPTH        = 4;
  localparam int RSP_CYCLES_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Command FIFO: array storage with wrapping pointers and an occupancy counter.
module wb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign full    = (count_reg == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count_reg != '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/wb_cmd_seq.sv
// Queues bus commands and issues them one at a time to a Wishbone master,
// returning read data, write echo and a start-to-done cycle count.
module wb_cmd_seq
  import wb_seq_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH   = DATA_WIDTH / 8,
  parameter int WBS_ADDR_LSB = $clog2(BYTE_WIDTH),
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [ADDR_WIDTH-WBS_ADDR_LSB-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]              cmd_data,
  input  logic [BYTE_WIDTH-1:0]              cmd_sel,
  input  logic                               cmd_we,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  output logic                               rsp_we,
  output logic [RSP_CYCLES_WIDTH-1:0]        rsp_cycles,
  output logic                               m_start,
  output logic [ADDR_WIDTH-WBS_ADDR_LSB-1:0] m_addr,
  output logic [DATA_WIDTH-1:0]              m_data,
  output logic [BYTE_WIDTH-1:0]              m_sel,
  output logic                               m_we,
  input  logic [DATA_WIDTH-1:0]              m_rdata,
  input  logic                               m_done,
  output logic [$clog2(DEPTH):0]             fifo_count,
  output logic                               err_spurious
);

  localparam int WA = ADDR_WIDTH - WBS_ADDR_LSB;
  localparam int FW = WA + DATA_WIDTH + BYTE_WIDTH + 1;

  seq_state_t state_reg, state_next;

  logic [FW-1:0]               fifo_din;
  logic [FW-1:0]               fifo_dout;
  logic                        fifo_full;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic [WA-1:0]               head_addr;
  logic [DATA_WIDTH-1:0]       head_data;
  logic [BYTE_WIDTH-1:0]       head_sel;
  logic                        head_we;

  logic [WA-1:0]               m_addr_reg;
  logic [DATA_WIDTH-1:0]       m_data_reg;
  logic [BYTE_WIDTH-1:0]       m_sel_reg;
  logic                        m_we_reg;
  logic                        rsp_valid_reg;
  logic [DATA_WIDTH-1:0]       rsp_data_reg;
  logic                        rsp_we_reg;
  logic [RSP_CYCLES_WIDTH-1:0] rsp_cycles_reg;
  logic                        err_reg;

  logic load_cmd;
  logic capture_rsp;
  logic clear_rsp;

  // Ready is held low during reset as well as when full.
  assign cmd_ready = aresetn && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_din  = {cmd_addr, cmd_data, cmd_sel, cmd_we};
  assign {head_addr, head_data, head_sel, head_we} = fifo_dout;

  wb_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    fifo_pop    = 1'b0;
    load_cmd    = 1'b0;
    capture_rsp = 1'b0;
    clear_rsp   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (fifo_count != '0) begin
          state_next = S_ISSUE;
          fifo_pop   = 1'b1;
          load_cmd   = 1'b1;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (m_done) begin
          state_next  = S_RESP;
          capture_rsp = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
          clear_rsp  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_addr_reg     <= '0;
      m_data_reg     <= '0;
      m_sel_reg      <= '0;
      m_we_reg       <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_we_reg     <= 1'b0;
      rsp_cycles_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (load_cmd) begin
        m_addr_reg     <= head_addr;
        m_data_reg     <= head_data;
        m_sel_reg      <= head_sel;
        m_we_reg       <= head_we;
        rsp_cycles_reg <= '0;
      end
      // The done cycle itself is counted, so the count spans start to done.
      if (state_reg == S_WAIT && rsp_cycles_reg != '1)
        rsp_cycles_reg <= rsp_cycles_reg + RSP_CYCLES_WIDTH'(1);
      if (capture_rsp) begin
        rsp_data_reg  <= m_we_reg ? '0 : m_rdata;
        rsp_we_reg    <= m_we_reg;
        rsp_valid_reg <= 1'b1;
      end
      if (clear_rsp) rsp_valid_reg <= 1'b0;
      if (m_done && state_reg != S_WAIT) err_reg <= 1'b1;
    end
  end

  assign m_start      = (state_reg == S_ISSUE);
  assign m_addr       = m_addr_reg;
  assign m_data       = m_data_reg;
  assign m_sel        = m_sel_reg;
  assign m_we         = m_we_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_data     = rsp_data_reg;
  assign rsp_we       = rsp_we_reg;
  assign rsp_cycles   = rsp_cycles_reg;
  assign err_spurious = err_reg;

endmodule

// File: tb/tb_wb_cmd_seq.sv
// Self-checking bench for wb_cmd_seq: vector table, scoreboard monitor and a
// simple master model with programmable ack delay.
module tb_wb_cmd_seq;

  localparam int AW = 29;
  localparam int DW = 64;
  localparam int BW = 8;

  logic          aclk;
  logic          aresetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [BW-1:0] cmd_sel;
  logic          cmd_we;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_we;
  logic [15:0]   rsp_cycles;
  logic          m_start;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [BW-1:0] m_sel;
  logic          m_we;
  logic [DW-1:0] m_rdata;
  logic          m_done;
  logic [2:0]    fifo_count;
  logic          err_spurious;

  logic model_done;
  logic spur_done;
  assign m_done = model_done | spur_done;

  wb_cmd_seq dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_sel      (cmd_sel),
    .cmd_we       (cmd_we),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_we       (rsp_we),
    .rsp_cycles   (rsp_cycles),
    .m_start      (m_start),
    .m_addr       (m_addr),
    .m_data       (m_data),
    .m_sel        (m_sel),
    .m_we         (m_we),
    .m_rdata      (m_rdata),
    .m_done       (m_done),
    .fifo_count   (fifo_count),
    .err_spurious (err_spurious)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] sel;
    logic          we;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          we;
    logic [15:0]   cycles;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] sel;
    logic          we;
    int            wt;
    logic [DW-1:0] exp_data;
    logic          exp_we;
    logic [15:0]   exp_cycles;
  } vec_t;

  cmd_t issue_q[$];
  rsp_t rsp_q[$];

  int tests = 0;
  int fails = 0;
  int master_wait = 0;
  bit master_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Master read data: fixed pattern, addr 0x10 returns DEADBEEF_CAFEF00D.
  function automatic logic [63:0] rdata_of(input logic [AW-1:0] a);
    return 64'hDEADBEEF_CAFEF00D ^ {35'd0, a} ^ 64'h10;
  endfunction

  // Master model: m_done arrives master_wait cycles after the first wait cycle.
  initial begin
    bit pending;
    int cnt;
    pending    = 1'b0;
    cnt        = 0;
    model_done = 1'b0;
    m_rdata    = '0;
    forever begin
      @(negedge aclk);
      model_done = 1'b0;
      if (!aresetn) begin
        pending = 1'b0;
      end else begin
        if (pending && !master_stall) begin
          if (cnt == 0) begin
            model_done = 1'b1;
            m_rdata    = rdata_of(m_addr);
            pending    = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (m_start) begin
          pending = 1'b1;
          cnt     = master_wait;
        end
      end
    end
  end

  // Scoreboard monitor: issue order, held m_* during the wait, response contents.
  initial begin
    cmd_t cur;
    rsp_t exp_r;
    rsp_t got_r;
    bit   active;
    int   ctr;
    active = 1'b0;
    ctr    = 0;
    cur    = '{'0, '0, '0, 1'b0};
    forever begin
      @(negedge aclk);
      #2;
      if (!aresetn) begin
        issue_q.delete();
        rsp_q.delete();
        active = 1'b0;
      end else begin
        if (m_start) begin
          check("one_outstanding", {62'd0, active, rsp_valid}, 64'd0);
          if (issue_q.size() == 0) begin
            check("unexpected_m_start", {63'd0, m_start}, 64'd0);
          end else begin
            cur = issue_q.pop_front();
            check("m_addr", {35'd0, m_addr}, {35'd0, cur.addr});
            check("m_data", m_data, cur.data);
            check("m_sel_we", {55'd0, m_sel, m_we}, {55'd0, cur.sel, cur.we});
          end
          active = 1'b1;
          ctr    = 0;
        end else if (active) begin
          ctr++;
          if (m_done) begin
            check("m_addr_held", {35'd0, m_addr}, {35'd0, cur.addr});
            exp_r.data   = cur.we ? 64'd0 : rdata_of(cur.addr);
            exp_r.we     = cur.we;
            exp_r.cycles = 16'(ctr);
            rsp_q.push_back(exp_r);
            active = 1'b0;
          end
        end
        if (rsp_valid && rsp_ready) begin
          if (rsp_q.size() == 0) begin
            check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
          end else begin
            got_r = rsp_q.pop_front();
            check("sb_rsp_data", rsp_data, got_r.data);
            check("sb_rsp_we_cycles", {47'd0, rsp_we, rsp_cycles}, {47'd0, got_r.we, got_r.cycles});
          end
        end
      end
    end
  end

  task automatic drive_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [BW-1:0] s, input logic w, input bit sync,
                           output bit acc);
    if (sync) @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_sel   = s;
    cmd_we    = w;
    #1;
    acc = cmd_ready;
    if (acc) issue_q.push_back('{a, d, s, w});
  endtask

  task automatic push_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] s, input logic w, output bit acc);
    drive_cmd(a, d, s, w, 1'b1, acc);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      #2;
      n++;
    end while (!rsp_valid && n < 200);
    check("rsp_arrives", {63'd0, rsp_valid}, 64'd1);
  endtask

  // Returns at the negedge of the first S_IDLE cycle after the handshake.
  task automatic ack();
    @(negedge aclk);
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
  endtask

  task automatic ack_rsp();
    wait_rsp();
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  vec_t vecs[4];

  initial begin
    bit acc;
    int lat;
    int n_acc;
    int starts;

    // rsp_cycles = wait cycles + the done cycle
    vecs[0] = '{29'h10, 64'h0, 8'hFF, 1'b0, 3, 64'hDEADBEEF_CAFEF00D, 1'b0, 16'd4};
    vecs[1] = '{29'h20, 64'h11223344_55667788, 8'hFF, 1'b1, 0, 64'h0, 1'b1, 16'd1};
    vecs[2] = '{29'h30, 64'h0, 8'h0F, 1'b0, 1, 64'hDEADBEEF_CAFEF02D, 1'b0, 16'd2};
    vecs[3] = '{29'h1FFFFFFF, 64'hA5A5_5A5A_0F0F_F0F0, 8'h81, 1'b1, 5, 64'h0, 1'b1, 16'd6};

    aresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_sel   = '0;
    cmd_we    = 1'b0;
    rsp_ready = 1'b0;
    spur_done = 1'b0;

    repeat (3) @(negedge aclk);
    #2;
    check("rst_ready_count", {60'd0, cmd_ready, fifo_count}, 64'd0);
    check("rst_outputs", {61'd0, rsp_valid, m_start, err_spurious}, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    #2;
    check("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

    for (int i = 0; i < 4; i++) begin
      master_wait = vecs[i].wt;
      push_cmd(vecs[i].addr, vecs[i].data, vecs[i].sel, vecs[i].we, acc);
      check("vec_accept", {63'd0, acc}, 64'd1);
      #2;
      lat = 1;
      while (!m_start && lat < 20) begin
        @(negedge aclk);
        #2;
        lat++;
      end
      check("vec_start_latency", 64'(lat), 64'd2);
      wait_rsp();
      check("vec_rsp_data", rsp_data, vecs[i].exp_data);
      check("vec_rsp_we", {63'd0, rsp_we}, {63'd0, vecs[i].exp_we});
      check("vec_rsp_cycles", {48'd0, rsp_cycles}, {48'd0, vecs[i].exp_cycles});
      ack();
      $display("[TB] vector %0d addr=%h we=%0d done", i, vecs[i].addr, vecs[i].we);
    end

    // Fill / overflow with a stalled master.
    master_stall = 1'b1;
    master_wait  = 0;
    push_cmd(29'h100, 64'h100, 8'hFF, 1'b0, acc);
    repeat (3) @(negedge aclk);
    n_acc = 0;
    for (int i = 1; i <= 5; i++) begin
      drive_cmd(29'(32'h100 + i), 64'(i) << 8, 8'(i), 1'(i % 2), 1'b1, acc);
      if (acc) n_acc++;
    end
    @(negedge aclk);
    cmd_valid = 1'b0;
    #2;
    check("fill_accepts", 64'(n_acc), 64'd4);
    check("fill_count", {61'd0, fifo_count}, 64'd4);
    check("fill_ready_low", {63'd0, cmd_ready}, 64'd0);
    master_stall = 1'b0;
    ack_rsp();
    check("full_pop_count", {61'd0, fifo_count}, 64'd4);
    drive_cmd(29'h1F0, 64'h1F0, 8'h3C, 1'b0, 1'b0, acc);
    check("full_pop_ready", {63'd0, acc}, 64'd0);
    @(negedge aclk);
    cmd_valid = 1'b0;
    #2;
    check("after_pop_count", {61'd0, fifo_count}, 64'd3);
    ack_rsp();
    drive_cmd(29'h1F0, 64'h1F0, 8'h3C, 1'b0, 1'b0, acc);
    check("pushpop_accept", {63'd0, acc}, 64'd1);
    @(negedge aclk);
    cmd_valid = 1'b0;
    #2;
    check("pushpop_count", {61'd0, fifo_count}, 64'd3);
    repeat (4) ack_rsp();
    #2;
    check("drained_count", {61'd0, fifo_count}, 64'd0);
    $display("[TB] fill/overflow sequence done");

    // Back-pressure: response held while rsp_ready stays low.
    master_wait = 2;
    push_cmd(29'h40, 64'h0, 8'hFF, 1'b0, acc);
    push_cmd(29'h44, 64'h4444, 8'hF0, 1'b1, acc);
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      #2;
      check("bp_hold", {rsp_data[61:0], rsp_valid, m_start},
            {rdata_of(29'h40) & 64'h3FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
    end
    ack();
    ack_rsp();
    $display("[TB] back-pressure sequence done");

    // Spurious m_done while idle.
    #2;
    check("err_clear_before", {63'd0, err_spurious}, 64'd0);
    @(negedge aclk);
    spur_done = 1'b1;
    @(negedge aclk);
    spur_done = 1'b0;
    #2;
    check("err_set", {62'd0, err_spurious, rsp_valid}, 64'd2);
    repeat (5) @(negedge aclk);
    #2;
    check("err_sticky", {62'd0, err_spurious, rsp_valid}, 64'd2);
    $display("[TB] spurious done sequence done");

    // Reset during S_WAIT with three commands queued.
    master_stall = 1'b1;
    push_cmd(29'h200, 64'h200, 8'hFF, 1'b0, acc);
    repeat (3) @(negedge aclk);
    for (int i = 1; i <= 3; i++) push_cmd(29'(32'h200 + i), 64'(i), 8'hFF, 1'b1, acc);
    #2;
    check("pre_rst_count", {61'd0, fifo_count}, 64'd3);
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    #2;
    check("rst_rsp", {47'd0, rsp_valid, rsp_cycles}, 64'd0);
    check("rst_rsp_data_we", rsp_data | {63'd0, rsp_we}, 64'd0);
    check("rst_m", {25'd0, m_start, m_we, m_sel, m_addr}, 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_status", {59'd0, err_spurious, fifo_count, cmd_ready}, 64'd0);
    @(negedge aclk);
    aresetn      = 1'b1;
    master_stall = 1'b0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      #2;
      if (m_start) starts++;
    end
    check("no_start_after_rst", 64'(starts), 64'd0);
    master_wait = 1;
    push_cmd(29'h300, 64'h0, 8'hFF, 1'b0, acc);
    check("post_rst_accept", {63'd0, acc}, 64'd1);
    wait_rsp();
    check("post_rst_rsp", rsp_data, rdata_of(29'h300));
    ack();
    $display("[TB] reset sequence done");

    repeat (3) @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
